// File: rtl/isp_loader.sv
// isp_loader: in-system programming loader.
//
// Parses a framed program image from a UART byte stream and writes it into
// instruction RAM as a Wishbone classic master. Holds the core in reset until
// a frame has loaded successfully.
//
// Frame: SYNC_BYTE, ADDR (4B LE), LEN (2B LE word count N), DATA (4N B LE),
// and an optional SUM byte (mod-256 sum of every byte after SYNC).
//
// Build option: define ISP_CHECKSUM_EN to expect and verify the SUM byte.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   isp_data_i, isp_valid_i   received byte and its one-cycle strobe
//   wb_*                      Wishbone classic write master (sel always 4'hF)
//   core_rst_o                high holds the core in reset
//   busy_o                    a frame is being parsed
//   done_o                    image loaded successfully
//   err_o                     the last frame failed
module isp_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  isp_data_i,
    input  logic        isp_valid_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StAddr, StLen, StData, StSum, StDone, StErr
    } state_e;

`ifdef ISP_CHECKSUM_EN
    localparam state_e StTail = StSum;
`else
    localparam state_e StTail = StDone;
`endif

    state_e          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     addr_q, addr_d;      // ADDR shift register, then next write address
    logic [15:0]     len_q, len_d;
    logic [15:0]     words_q, words_d;    // words issued so far
    logic [31:0]     word_q, word_d;      // data word being assembled
    logic            cyc_q, cyc_d;
    logic [31:0]     wb_adr_q, wb_adr_d;
    logic [31:0]     wb_dat_q, wb_dat_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
`ifdef ISP_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic        busy;
    logic        take;     // byte belongs to the frame payload (ADDR/LEN/DATA)
    logic        restart;  // SYNC accepted
    logic [31:0] addr_sh;
    logic [15:0] len_sh;
    logic [31:0] word_sh;

    assign busy = (state_q == StAddr) || (state_q == StLen) ||
                  (state_q == StData) || (state_q == StSum);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        words_d    = words_q;
        word_d     = word_q;
        cyc_d      = cyc_q;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;

        addr_sh = {isp_data_i, addr_q[31:8]};
        len_sh  = {isp_data_i, len_q[15:8]};
        word_sh = {isp_data_i, word_q[31:8]};

        // A restart from ERR waits until any write still in flight has finished.
        restart = isp_valid_i && (isp_data_i == SYNC_BYTE) &&
                  ((state_q == StIdle) || ((state_q == StErr) && !cyc_q));
        // Once all N words are issued, DATA only waits for the last ack.
        take = isp_valid_i && ((state_q == StAddr) || (state_q == StLen) ||
                               ((state_q == StData) && (words_q != len_q)));

        if (isp_valid_i) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end

        if (take) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
        if (cyc_q && (wb_ack_i || wb_err_i)) begin
            cyc_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StErr: begin
                if (restart) begin
                    state_d    = StAddr;
                    byte_cnt_d = '0;
                    words_d    = '0;
                end
            end
            StAddr: begin
                if (take) begin
                    addr_d = addr_sh;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (addr_sh[1:0] != 2'b00) ? StErr : StLen;
                    end
                end
            end
            StLen: begin
                if (take) begin
                    len_d = len_sh;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = '0;
                        state_d    = (len_sh == 16'd0) ? StTail : StData;
                    end
                end
            end
            StData: begin
                if (cyc_q && wb_err_i) begin
                    state_d = StErr;
                end else if (cyc_q && wb_ack_i && (words_q == len_q)) begin
                    state_d = StTail;
                end else if (take) begin
                    word_d = word_sh;
                    if (byte_cnt_q == 2'd3) begin
                        if (cyc_q && !wb_ack_i) begin
                            // Overflow: previous write still pending; it is left to finish.
                            state_d = StErr;
                        end else begin
                            cyc_d    = 1'b1;
                            wb_adr_d = addr_q;
                            wb_dat_d = word_sh;
                            addr_d   = addr_q + 32'd4;
                            words_d  = words_q + 16'd1;
                        end
                    end
                end
            end
            StSum: begin
`ifdef ISP_CHECKSUM_EN
                if (isp_valid_i) begin
                    state_d = (isp_data_i == sum_q) ? StDone : StErr;
                end
`else
                state_d = StErr;
`endif
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        if (busy && !isp_valid_i && !cyc_q && (tmo_q == TmoMax)) begin
            state_d = StErr;
        end
    end

`ifdef ISP_CHECKSUM_EN
    always_comb begin
        sum_d = sum_q;
        if (restart) begin
            sum_d = '0;
        end else if (take) begin
            sum_d = sum_q + isp_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            word_q     <= '0;
            cyc_q      <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            words_q    <= words_d;
            word_q     <= word_d;
            cyc_q      <= cyc_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            tmo_q      <= tmo_d;
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = cyc_q;
    assign wb_adr_o   = wb_adr_q;
    assign wb_dat_o   = wb_dat_q;
    assign wb_sel_o   = 4'hF;
    assign core_rst_o = (state_q != StDone);
    assign busy_o     = busy;
    assign done_o     = (state_q == StDone);
    assign err_o      = (state_q == StErr);

endmodule

// File: tb/tb_isp_loader.sv
// Self-checking bench for isp_loader: directed scenarios plus randomized frames
// checked against a frame-level model (expected write list and final outcome).
module tb_isp_loader;

    localparam int unsigned Tmo = 20;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  isp_data_i;
    logic        isp_valid_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic        core_rst_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    isp_loader #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .isp_data_i (isp_data_i),
        .isp_valid_i(isp_valid_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .core_rst_o (core_rst_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [7:0]  frame[$];
    logic [31:0] words[8];
    logic [7:0]  last_sum;
    int          sum_gap_idx;

    int ack_lat   = 1;
    bit ack_stall = 1'b0;
    bit err_next  = 1'b0;
    int wait_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Slave responder: acks after a random 0..2 cycle wait, or errors once on request.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o && !ack_stall) begin
                if (wait_cnt >= ack_lat) begin
                    if (err_next) begin
                        wb_err_i = 1'b1;
                        err_next = 1'b0;
                    end else begin
                        wb_ack_i = 1'b1;
                    end
                    wait_cnt = 0;
                    ack_lat  = $urandom_range(0, 2);
                end else begin
                    wait_cnt++;
                end
            end else if (!wb_cyc_o) begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process: bus protocol and write contents every cycle.
    initial begin
        logic prev_cyc;
        logic prev_resp;
        logic [31:0] ea, ed;
        prev_cyc  = 1'b0;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_cyc  = 1'b0;
                prev_resp = 1'b0;
            end else begin
                check("sel", wb_sel_o, 4'hF);
                check("core_rst_vs_done", core_rst_o, !done_o);
                if (wb_cyc_o) begin
                    check("stb_with_cyc", wb_stb_o, 1'b1);
                    check("we_with_stb", wb_we_o, 1'b1);
                end
                if (prev_resp) check("cyc_drop_on_resp", wb_cyc_o, 1'b0);
                if (wb_cyc_o && !prev_cyc) begin
                    n_cmp++;
                    if (exp_adr_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_write: got write @%h data %h, want none",
                                 wb_adr_o, wb_dat_o);
                    end else begin
                        ea = exp_adr_q.pop_front();
                        ed = exp_dat_q.pop_front();
                        check("wr_adr", wb_adr_o, ea);
                        check("wr_dat", wb_dat_o, ed);
                    end
                end
                prev_cyc  = wb_cyc_o;
                prev_resp = wb_cyc_o && (wb_ack_i || wb_err_i);
            end
        end
    end

    // Frame builder; the model checksum is the plain byte sum after SYNC.
    task automatic build_frame(input logic [31:0] addr, input int n, input bit corrupt,
                               input bit hdr_only);
        logic [7:0]  s;
        logic [15:0] n16;
        frame.delete();
        sum_gap_idx = -1;
        frame.push_back(8'hA5);
        for (int i = 0; i < 4; i++) frame.push_back(addr[8*i +: 8]);
        if (hdr_only) return;
        n16 = 16'(n);
        frame.push_back(n16[7:0]);
        frame.push_back(n16[15:8]);
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 4; b++) frame.push_back(words[w][8*b +: 8]);
        s = 8'h00;
        for (int i = 1; i < frame.size(); i++) s = s + frame[i];
        last_sum = s;
`ifdef ISP_CHECKSUM_EN
        sum_gap_idx = frame.size() - 1;  // leave room for the last ack before SUM
        frame.push_back(corrupt ? s + 8'd1 : s);
`else
        if (corrupt) $display("note: corrupt ignored without checksum");
`endif
    endtask

    task automatic push_writes(input logic [31:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            exp_adr_q.push_back(addr + 32'(4 * i));
            exp_dat_q.push_back(words[i]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        isp_data_i  = b;
        isp_valid_i = 1'b1;
        step(1);
        isp_valid_i = 1'b0;
        step(gap);
    endtask

    task automatic send_frame(input int max_gap, input int limit);
        for (int i = 0; i < limit; i++) begin
            int g;
            g = (i == sum_gap_idx) ? 6 : $urandom_range(0, max_gap);
            send_byte(frame[i], g);
            if (i == 0) check("busy_after_sync", busy_o, 1'b1);
        end
    endtask

    task automatic wait_outcome(input bit exp_done, input string tag);
        int i;
        i = 0;
        while (((!done_o && !err_o) || wb_cyc_o) && i < 100) begin
            step(1);
            i++;
        end
        check({tag, "_done"}, done_o, exp_done);
        check({tag, "_err"}, err_o, !exp_done);
        check({tag, "_core_rst"}, core_rst_o, !exp_done);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_writes_left"}, exp_adr_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        isp_valid_i = 1'b0;
        ack_stall   = 1'b0;
        err_next    = 1'b0;
        step(2);
        exp_adr_q.delete();
        exp_dat_q.delete();
        rst_i = 1'b0;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        isp_data_i  = 8'h00;
        isp_valid_i = 1'b0;
        step(2);
        // Reset values.
        check("rst_core_rst", core_rst_o, 1'b1);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", wb_sel_o, 4'hF);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b0;
        step(1);

        // Good frame from the test plan.
        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        build_frame(32'h0, 2, 1'b0, 1'b0);
        check("model_sum_pin", last_sum, 8'h4E);
`ifdef ISP_CHECKSUM_EN
        check("model_len_pin", frame.size(), 16);
`else
        check("model_len_pin", frame.size(), 15);
`endif
        push_writes(32'h0, 2);
        check("model_adr1_pin", exp_adr_q[1], 32'h4);
        check("model_dat1_pin", exp_dat_q[1], 32'hDEADBEEF);
        send_frame(2, frame.size());
        wait_outcome(1'b1, "good");

`ifdef ISP_CHECKSUM_EN
        // Bad checksum, then a good frame without reset.
        do_reset();
        build_frame(32'h0, 2, 1'b1, 1'b0);
        push_writes(32'h0, 2);
        send_frame(2, frame.size());
        wait_outcome(1'b0, "badsum");
        build_frame(32'h0, 2, 1'b0, 1'b0);
        push_writes(32'h0, 2);
        send_frame(2, frame.size());
        wait_outcome(1'b1, "after_badsum");
`endif

        // Misaligned address.
        do_reset();
        build_frame(32'h2, 0, 1'b0, 1'b1);
        send_frame(2, frame.size());
        wait_outcome(1'b0, "misaligned");

        // Ack stall: second word completes while the first is pending.
        do_reset();
        ack_stall = 1'b1;
        words[0]  = 32'hCAFEF00D;
        words[1]  = 32'h0BADBEEF;
        build_frame(32'h100, 2, 1'b0, 1'b0);
        push_writes(32'h100, 1);
        send_frame(0, 15);
        check("stall_err", err_o, 1'b1);
        check("stall_cyc_held", wb_cyc_o, 1'b1);
        step(5);
        check("stall_cyc_still_held", wb_cyc_o, 1'b1);
        ack_stall = 1'b0;
        for (int i = 0; i < 10 && wb_cyc_o; i++) step(1);
        check("stall_cyc_released", wb_cyc_o, 1'b0);
        check("stall_err_final", err_o, 1'b1);
        check("stall_writes_left", exp_adr_q.size(), 0);

        // Timeout in LEN.
        do_reset();
        build_frame(32'h200, 1, 1'b0, 1'b0);
        send_frame(0, 6);
        step(15);
        check("tmo_early_err", err_o, 1'b0);
        check("tmo_early_busy", busy_o, 1'b1);
        step(15);
        check("tmo_err", err_o, 1'b1);
        check("tmo_busy", busy_o, 1'b0);

        // Bus error on word 1.
        do_reset();
        ack_lat  = 0;
        err_next = 1'b1;
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        build_frame(32'h300, 2, 1'b0, 1'b0);
        push_writes(32'h300, 1);
        send_frame(0, 11);
        for (int i = 0; i < 10 && !wb_cyc_o; i++) step(1);
        check("wberr_cyc_up", wb_cyc_o, 1'b1);
        step(1);
        check("wberr_cyc_drop", wb_cyc_o, 1'b0);
        check("wberr_err", err_o, 1'b1);
        check("wberr_writes_left", exp_adr_q.size(), 0);

        // N = 0.
        do_reset();
        build_frame(32'h400, 0, 1'b0, 1'b0);
        send_frame(2, frame.size());
        wait_outcome(1'b1, "n0");

        // Address wrap.
        do_reset();
        words[0] = 32'hA0A1A2A3;
        words[1] = 32'hB0B1B2B3;
        build_frame(32'hFFFF_FFFC, 2, 1'b0, 1'b0);
        push_writes(32'hFFFF_FFFC, 2);
        check("model_wrap_pin", exp_adr_q[1], 32'h0);
        send_frame(2, frame.size());
        wait_outcome(1'b1, "wrap");

        // Reset mid-cycle.
        do_reset();
        ack_stall = 1'b1;
        words[0]  = 32'h600D600D;
        build_frame(32'h500, 1, 1'b0, 1'b0);
        push_writes(32'h500, 1);
        send_frame(0, 11);
        check("midrst_cyc_before", wb_cyc_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("midrst_cyc", wb_cyc_o, 1'b0);
        check("midrst_stb", wb_stb_o, 1'b0);
        check("midrst_core_rst", core_rst_o, 1'b1);
        check("midrst_busy", busy_o, 1'b0);
        do_reset();

        // Randomized frames, chained after failures, reset after success.
        for (int f = 0; f < 40; f++) begin
            bit          mis;
            bit          cor;
            int          n;
            int          ngarb;
            logic [31:0] a;
            logic [7:0]  gb;
            if (done_o) do_reset();
            ngarb = $urandom_range(0, 2);
            for (int g = 0; g < ngarb; g++) begin
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h00;
                send_byte(gb, $urandom_range(0, 2));
            end
            mis = ($urandom_range(0, 4) == 0);
            a   = $urandom;
            a[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
            n   = $urandom_range(0, 4);
`ifdef ISP_CHECKSUM_EN
            cor = ($urandom_range(0, 3) == 0);
`else
            cor = 1'b0;
`endif
            for (int w = 0; w < 8; w++) words[w] = $urandom;
            build_frame(a, n, cor, mis);
            if (!mis) push_writes(a, n);
            send_frame(2, frame.size());
            wait_outcome(!mis && !cor, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
